// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage downstream of branchlogic.
// Selects the next fetch address from halt/ret/call/jump/branch strobes in
// fixed priority, supplies the call return address, and handles HALTED.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken counters.
module pc_sequencer #(
    parameter int unsigned           PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
    parameter int unsigned           PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                br_valid,
    input  logic                branch,
    input  logic                jump,
    input  logic                call,
    input  logic                ret,
    input  logic                halt_req,
    input  logic                resume,
    input  logic [PC_WIDTH-1:0] target,
    input  logic [PC_WIDTH-1:0] reg_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                link_we,
    output logic [PC_WIDTH-1:0] link_data,
    output logic                redirect,
`ifdef BRANCH_STATS_EN
    output logic [15:0]         br_taken_cnt,
    output logic [15:0]         br_nt_cnt,
`endif
    output logic                halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                run_go;
    logic                direct_tgt;

    assign pc_inc     = pc + PC_WIDTH'(PC_STEP);
    assign direct_tgt = call | jump | (br_valid & branch);

    // Decode of the current instruction into side-effect strobes
    always_comb begin
        run_go    = (state == RUN) && !stall && !rst;
        redirect  = 1'b0;
        link_we   = 1'b0;
        link_data = pc_inc;
        if (run_go && !halt_req) begin
            redirect = ret | direct_tgt;
            link_we  = !ret && call;
        end
    end

    // PC register and RUN/HALTED state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (halt_req) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else if (ret) begin
                            pc <= reg_target;
                        end else if (direct_tgt) begin
                            pc <= target;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        pc     <= pc_inc;
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic count_taken;
    logic count_nt;

    assign count_taken = (state == RUN) && !stall && br_valid && branch &&
                         !halt_req && !ret && !call && !jump;
    assign count_nt    = (state == RUN) && !stall && br_valid && !branch;

    // Saturating branch outcome counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_taken_cnt <= 16'h0000;
            br_nt_cnt    <= 16'h0000;
        end else begin
            if (count_taken && (br_taken_cnt != 16'hFFFF))
                br_taken_cnt <= br_taken_cnt + 16'd1;
            if (count_nt && (br_nt_cnt != 16'hFFFF))
                br_nt_cnt <= br_nt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of branchlogic. Consumes the `branch` decision together with decoder jump/call/return/halt strobes and produces the fetch address for the next cycle.
- Also supplies the return address for call, which is written to the register file in the same cycle.
- Single-cycle datapath: the control inputs always describe the instruction at the current `pc`.

Parameters:
- PC_WIDTH, 32, width of the PC and of all address ports.
- RESET_PC, 0, PC value on reset.
- PC_STEP, 1, increment between sequential instructions (word addressing).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and suppress all side effects this cycle.
- br_valid  in  1  current instruction is a conditional branch.
- branch  in  1  taken decision from branchlogic; meaningful only when br_valid=1.
- jump  in  1  unconditional direct jump.
- call  in  1  direct jump plus link.
- ret  in  1  jump to the register value.
- halt_req  in  1  current instruction is halt.
- resume  in  1  leave the HALTED state.
- target  in  PC_WIDTH  absolute direct target (branch/jump/call).
- reg_target  in  PC_WIDTH  register operand used by ret.
- pc  out  PC_WIDTH  registered fetch address.
- link_we  out  1  combinational register-file write enable for the return address.
- link_data  out  PC_WIDTH  combinational value pc+PC_STEP.
- redirect  out  1  combinational; PC updates non-sequentially at the next edge.
- halted  out  1  registered; 1 while in the HALTED state.

Behaviour:
- Reset (async, any time, including mid-halt or mid-stall):
  - pc=RESET_PC, state=RUN, halted=0.
  - link_we=0 and redirect=0 while rst is high.
- States: RUN, HALTED. `halted` = (state==HALTED).
- RUN with stall=1: pc holds; link_we=0; redirect=0; halt_req is ignored; state stays RUN.
- RUN with stall=0, at the edge, fixed priority:
  1. halt_req: pc holds (keeps the halt address); state->HALTED.
  2. ret: pc<=reg_target; redirect=1.
  3. call: pc<=target; redirect=1; link_we=1; link_data=pc+PC_STEP.
  4. jump: pc<=target; redirect=1.
  5. br_valid & branch: pc<=target; redirect=1.
  6. Otherwise (including br_valid & !branch): pc<=pc+PC_STEP; redirect=0.
- Multiple strobes asserted together: the highest priority wins; lower ones have no effect, so call masked by ret gives link_we=0.
- branch with br_valid=0 is ignored.
- HALTED:
  - pc holds; link_we=0; redirect=0; all control strobes and stall are ignored.
  - resume=1: pc<=pc+PC_STEP, state->RUN.
  - resume asserted in RUN is ignored.
- Arithmetic: pc+PC_STEP wraps modulo 2^PC_WIDTH, so an all-ones PC with step 1 gives 0. No alignment checks on target or reg_target.
- link_data is driven as pc+PC_STEP at all times; only link_we qualifies it.
- Latency: a decision in cycle N is visible on `pc` after edge N. There are no bubbles and no flush cycles.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds outputs:
  - br_taken_cnt [15:0]: increments in a RUN, non-stalled cycle with br_valid=1 and branch=1, but only when no higher-priority strobe is active.
  - br_nt_cnt [15:0]: increments in a RUN, non-stalled cycle with br_valid=1 and branch=0.
- Both counters saturate at 16'hFFFF, reset to 0 with rst, and are unaffected by HALTED or stall.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset behaviour: assert rst mid-cycle with pc=0x40 -> pc=0x0 immediately, no clock edge needed; release rst, 3 idle cycles -> pc=1,2,3.
- Conditional branch: pc=5, br_valid=1, branch=1, target=0x20 -> redirect=1, pc=0x20 next cycle. Then br_valid=1, branch=0 -> pc=0x21, redirect=0.
- Call: pc=0x10, call=1, target=0x80 -> link_we=1, link_data=0x11 that cycle, pc=0x80. Then ret=1, reg_target=0x11 -> pc=0x11.
- Priority and stall: ret=1, call=1, reg_target=0x30, target=0x50 -> pc=0x30, link_we=0. Next, stall=1 with jump=1 -> pc holds at 0x30, redirect=0.
- Halt: halt_req=1 at pc=0x7 -> halted=1, pc stays 0x7 for 5 cycles despite jump=1; resume=1 -> pc=0x8, halted=0.
- Wrap and counters: PC_WIDTH=8, pc=0xFF, sequential -> pc=0x00. With BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> br_taken_cnt=3, br_nt_cnt=2.
